mem_responder: RTL and testbench

Synthesizable responder end of the AURA tagged memory protocol: accepts MEM_LOAD/MEM_STORE commands from the accelerator's memory master, allocates transaction tags, and returns load data tagged after a fixed latency. Sits opposite the accelerator top's proc2mem/mem2proc ports and serves as the on-chip backing store for Q/K/V/O blocks in FPGA/emulation builds and end-to-end benches.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_tag_pool.sv | 55 +++++
 rtl/mem_responder.sv | 101 ++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the tagged memory responder
//   MEM_TAG / MEM_BLOCK / ADDR : tag, data block and byte address widths
//   MEM_COMMAND                : command encoding on proc2mem_command
//   pipe_entry_t               : one slot of the load latency pipeline
package mem_responder_pkg;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [31:0] ADDR;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  localparam int NUM_MEM_TAGS    = 15;
  localparam int MEM_BLOCK_BYTES = 8;

  typedef struct packed {
    logic     valid;
    MEM_TAG   tag;
    MEM_BLOCK data;
  } pipe_entry_t;

endpackage

// File: rtl/mem_responder_tag_pool.sv
// rtl/mem_responder_tag_pool.sv - free bitmap of load tags 1..15 with lowest-free grant
//   clk, rst     : clock, asynchronous active-high reset (all tags free)
//   alloc_req    : consume the offered tag at this edge
//   free_valid   : return free_tag to the pool at this edge
//   free_tag     : tag being returned
//   grant_valid  : at least one tag is free
//   grant_tag    : lowest-numbered free tag (0 when none)
module mem_tag_pool
  import mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  input  logic       free_valid,
  input  logic [3:0] free_tag,
  output logic       grant_valid,
  output logic [3:0] grant_tag
);

  logic [NUM_MEM_TAGS:1] free_q;
  logic [NUM_MEM_TAGS:1] free_d;

  // Descending scan so the last hit, and therefore the winner, is the lowest tag.
  always_comb begin
    grant_valid = 1'b0;
    grant_tag   = '0;
    for (int i = NUM_MEM_TAGS; i >= 1; i--) begin
      if (free_q[i]) begin
        grant_valid = 1'b1;
        grant_tag   = MEM_TAG'(i);
      end
    end
  end

  // The grant is taken from free_q, so a tag being freed this cycle is still
  // busy in free_q and cannot be handed out until the following cycle.
  always_comb begin
    free_d = free_q;
    if (free_valid && (free_tag != '0)) begin
      free_d[free_tag] = 1'b1;
    end
    if (alloc_req && grant_valid) begin
      free_d[grant_tag] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= '1;
    end else begin
      free_q <= free_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - tagged memory responder with fixed-latency load return
//   clk, rst                  : clock, asynchronous active-high reset
//   proc2mem_command          : MEM_NONE / MEM_LOAD / MEM_STORE
//   proc2mem_addr             : byte address, block index = addr[3 +: log2(MEM_DEPTH)]
//   proc2mem_data             : store data
//   mem2proc_transaction_tag  : tag granted to a load this cycle (0 = none)
//   mem2proc_data             : returned load data (0 when no return)
//   mem2proc_data_tag         : tag of returned data (0 = no return)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_transaction_tag,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_data_tag
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [IDX_W-1:0] blk_idx;
  logic             unused_addr;
  MEM_BLOCK         mem_q [MEM_DEPTH];
  MEM_BLOCK         rd_data;

  logic             is_load;
  logic             is_store;
  logic             load_acc;
  logic             grant_valid;
  MEM_TAG           grant_tag;

  pipe_entry_t      pipe_q [MEM_LATENCY];
  pipe_entry_t      pipe_d [MEM_LATENCY];
  pipe_entry_t      ret;

  assign blk_idx     = proc2mem_addr[3 +: IDX_W];
  assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[31:3+IDX_W]};

  assign is_load  = (proc2mem_command == MEM_LOAD);
  assign is_store = (proc2mem_command == MEM_STORE);
  // Loads are refused while reset is held so nothing enters the pipeline.
  assign load_acc = is_load && grant_valid && !rst;

  assign mem2proc_transaction_tag = load_acc ? grant_tag : '0;

  assign ret               = pipe_q[MEM_LATENCY-1];
  assign mem2proc_data     = ret.valid ? ret.data : '0;
  assign mem2proc_data_tag = ret.valid ? ret.tag  : '0;

  mem_tag_pool u_tag_pool (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (load_acc),
    .free_valid  (ret.valid),
    .free_tag    (ret.tag),
    .grant_valid (grant_valid),
    .grant_tag   (grant_tag)
  );

  // Backing store: no reset, contents survive rst and are undefined until written.
  always_ff @(posedge clk) begin
    if (is_store) begin
      mem_q[blk_idx] <= proc2mem_data;
    end
  end

  // The load captures the block here, at acceptance, so later stores to the
  // same block cannot alter the value already in flight.
  assign rd_data = mem_q[blk_idx];

  always_comb begin
    for (int i = 0; i < MEM_LATENCY; i++) begin
      pipe_d[i] = '0;
    end
    pipe_d[0].valid = load_acc;
    pipe_d[0].tag   = load_acc ? grant_tag : '0;
    pipe_d[0].data  = load_acc ? rd_data   : '0;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder at latencies 4, 20 and 1
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = MEM_NONE;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;

  logic [3:0]  tt_o [3];
  logic [63:0] dd_o [3];
  logic [3:0]  dt_o [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.MEM_LATENCY(4), .MEM_DEPTH(1024)) u4 (
    .clk(clk), .rst(rst), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_transaction_tag(tt_o[0]),
    .mem2proc_data(dd_o[0]), .mem2proc_data_tag(dt_o[0]));

  mem_responder #(.MEM_LATENCY(20), .MEM_DEPTH(1024)) u20 (
    .clk(clk), .rst(rst), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_transaction_tag(tt_o[1]),
    .mem2proc_data(dd_o[1]), .mem2proc_data_tag(dt_o[1]));

  mem_responder #(.MEM_LATENCY(1), .MEM_DEPTH(1024)) u1 (
    .clk(clk), .rst(rst), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_transaction_tag(tt_o[2]),
    .mem2proc_data(dd_o[2]), .mem2proc_data_tag(dt_o[2]));

  // Reference model: per-instance free set and in-flight list keyed by return cycle.
  typedef struct {
    int          rc;
    int          tag;
    logic [63:0] d;
  } fl_t;

  int          lat [3] = '{4, 20, 1};
  bit          free_m [3][16];
  fl_t         q [3][$];
  logic [63:0] mm [int];
  int          cyc_n = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      q[u].delete();
      for (int t = 1; t <= 15; t++) free_m[u][t] = 1'b1;
    end
  endtask

  // Called at the falling edge: compares this cycle's outputs, then advances
  // the model to the state the next rising edge should produce.
  task automatic model_cycle();
    int blk;
    blk = int'((addr >> 3) % 1024);
    for (int u = 0; u < 3; u++) begin
      int g;
      int rt;
      logic [63:0] rd;
      g = 0; rt = 0; rd = '0;
      if (!rst && cmd == MEM_LOAD) begin
        for (int t = 15; t >= 1; t--) if (free_m[u][t]) g = t;
      end
      if (!rst && q[u].size() > 0 && q[u][0].rc == cyc_n) begin
        rt = q[u][0].tag;
        rd = q[u][0].d;
      end
      chk($sformatf("model_ttag_u%0d", u), 64'(tt_o[u]), 64'(g));
      chk($sformatf("model_dtag_u%0d", u), 64'(dt_o[u]), 64'(rt));
      chk($sformatf("model_data_u%0d", u), dd_o[u], rd);
      if (rst) begin
        q[u].delete();
        for (int t = 1; t <= 15; t++) free_m[u][t] = 1'b1;
      end else begin
        if (rt != 0) begin
          void'(q[u].pop_front());
          free_m[u][rt] = 1'b1;
        end
        if (g != 0) begin
          free_m[u][g] = 1'b0;
          q[u].push_back('{cyc_n + lat[u], g, mm[blk]});
        end
      end
    end
    if (cmd == MEM_STORE) mm[blk] = wdata;
    cyc_n++;
  endtask

  task automatic cyc(input logic r, input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    rst = r; cmd = c; addr = a; wdata = d;
    @(negedge clk);
    model_cycle();
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [63:0] d;
    logic [3:0]  tt;
    logic [3:0]  dt;
    logic [63:0] dd;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [63:0] va, vb, vc;
    va = 64'h0123_4567_89AB_CDEF;
    vb = 64'hFEDC_BA98_7654_3210;
    vc = 64'h5555_AAAA_0F0F_F0F0;
    tbl[0]  = '{MEM_STORE, 32'h40, 64'hDEADBEEF_00000001, 4'd0, 4'd0, 64'h0};
    tbl[1]  = '{MEM_LOAD,  32'h40, 64'h0, 4'd1, 4'd0, 64'h0};
    tbl[2]  = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd0, 64'h0};
    tbl[3]  = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd0, 64'h0};
    tbl[4]  = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd0, 64'h0};
    tbl[5]  = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd1, 64'hDEADBEEF_00000001};
    tbl[6]  = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd0, 64'h0};
    tbl[7]  = '{MEM_STORE, 32'h0,  va,    4'd0, 4'd0, 64'h0};
    tbl[8]  = '{MEM_STORE, 32'h8,  vb,    4'd0, 4'd0, 64'h0};
    tbl[9]  = '{MEM_STORE, 32'h10, vc,    4'd0, 4'd0, 64'h0};
    tbl[10] = '{MEM_LOAD,  32'h0,  64'h0, 4'd1, 4'd0, 64'h0};
    tbl[11] = '{MEM_LOAD,  32'h8,  64'h0, 4'd2, 4'd0, 64'h0};
    tbl[12] = '{MEM_LOAD,  32'h10, 64'h0, 4'd3, 4'd0, 64'h0};
    tbl[13] = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd0, 64'h0};
    tbl[14] = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd1, va};
    tbl[15] = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd2, vb};
    tbl[16] = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd3, vc};
    tbl[17] = '{MEM_NONE,  32'h0,  64'h0, 4'd0, 4'd0, 64'h0};

    model_reset();

    // Reset state with a load request pending: nothing granted, nothing returned.
    cyc(1'b1, MEM_LOAD, 32'h0, 64'h0);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset_ttag_u%0d", u), 64'(tt_o[u]), 64'h0);
      chk($sformatf("reset_dtag_u%0d", u), 64'(dt_o[u]), 64'h0);
    end
    cyc(1'b1, MEM_NONE, 32'h0, 64'h0);

    // Directed vectors on the latency-4 instance.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, tbl[i].c, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_ttag", i), 64'(tt_o[0]), 64'(tbl[i].tt));
      chk($sformatf("tbl%0d_dtag", i), 64'(dt_o[0]), 64'(tbl[i].dt));
      chk($sformatf("tbl%0d_data", i), dd_o[0], tbl[i].dd);
    end

    // Pool exhaustion at latency 20: 15 grants, then rejects until the cycle after tag 1 returns.
    cyc(1'b1, MEM_NONE, 32'h0, 64'h0);
    for (int j = 0; j < 22; j++) begin
      cyc(1'b0, MEM_LOAD, 32'h8, 64'h0);
      if (j < 15)       chk($sformatf("exh_grant%0d", j), 64'(tt_o[1]), 64'(j + 1));
      else if (j < 21)  chk($sformatf("exh_reject%0d", j), 64'(tt_o[1]), 64'h0);
      else              chk("exh_regrant", 64'(tt_o[1]), 64'h1);
      if (j == 20)      chk("exh_ret_tag1", 64'(dt_o[1]), 64'h1);
    end

    // In-flight snapshot versus a later store to the same block.
    cyc(1'b1, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_STORE, 32'h80, 64'h11);
    cyc(1'b0, MEM_LOAD, 32'h80, 64'h0);
    chk("snap_grant", 64'(tt_o[0]), 64'h1);
    cyc(1'b0, MEM_STORE, 32'h80, 64'h22);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    chk("snap_old_data", dd_o[0], 64'h11);
    chk("snap_old_tag", 64'(dt_o[0]), 64'h1);
    cyc(1'b0, MEM_LOAD, 32'h80, 64'h0);
    chk("snap_regrant", 64'(tt_o[0]), 64'h1);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    chk("snap_new_data", dd_o[0], 64'h22);

    // Reset with three loads in flight: outputs drop at once, nothing returns later.
    cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
    cyc(1'b0, MEM_LOAD, 32'h0, 64'h0);
    cyc(1'b0, MEM_LOAD, 32'h8, 64'h0);
    cyc(1'b0, MEM_LOAD, 32'h10, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cmd = MEM_LOAD;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("async_rst_ttag_u%0d", u), 64'(tt_o[u]), 64'h0);
      chk($sformatf("async_rst_dtag_u%0d", u), 64'(dt_o[u]), 64'h0);
      chk($sformatf("async_rst_data_u%0d", u), dd_o[u], 64'h0);
    end
    @(negedge clk);
    model_cycle();
    cyc(1'b1, MEM_LOAD, 32'h0, 64'h0);
    for (int j = 0; j < 6; j++) begin
      cyc(1'b0, MEM_NONE, 32'h0, 64'h0);
      chk($sformatf("post_rst_noret%0d", j), 64'(dt_o[0]), 64'h0);
    end
    cyc(1'b0, MEM_LOAD, 32'h0, 64'h0);
    for (int u = 0; u < 3; u++) chk($sformatf("post_rst_tag1_u%0d", u), 64'(tt_o[u]), 64'h1);

    // Latency 1: sustained loads alternate tags 1 and 2 with no rejects.
    cyc(1'b1, MEM_NONE, 32'h0, 64'h0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, MEM_LOAD, 32'(i % 3) * 8, 64'h0);
      chk($sformatf("lat1_grant%0d", i), 64'(tt_o[2]), 64'((i % 2) + 1));
      if (i > 0) chk($sformatf("lat1_ret%0d", i), 64'(dt_o[2]), 64'(((i - 1) % 2) + 1));
    end

    // Randomized traffic over a few blocks, with ignored address bits and occasional resets.
    cyc(1'b1, MEM_NONE, 32'h0, 64'h0);
    for (int b = 0; b < 8; b++) cyc(1'b0, MEM_STORE, 32'(b * 8), {$urandom, $urandom});
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  c;
      logic [31:0] a;
      logic        r;
      int          sel;
      sel = $urandom_range(0, 9);
      c = (sel < 6) ? MEM_LOAD : ((sel < 8) ? MEM_STORE : MEM_NONE);
      a = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 7)) << 3) | ($urandom & 32'h7);
      r = ($urandom_range(0, 63) == 0);
      cyc(r, c, a, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
